// File: rtl/button_event_scheduler_pkg.sv
// Shared constants, event-code layout and helpers for the button event scheduler.
package button_evt_pkg;

    localparam int EVT_W     = 3;
    localparam int NUM_REQ   = 8;
    localparam int KEY_BASE  = 0;
    localparam int CMD_BASE  = 4;
    localparam int CLASS_BIT = 2;
    localparam int IDX_LSB   = 0;

    typedef enum logic {
        CLS_KEY = 1'b0,
        CLS_CMD = 1'b1
    } evt_class_e;

    typedef logic [EVT_W-1:0] evt_code_t;

    function automatic evt_code_t make_code(evt_class_e cls, logic [1:0] idx);
        evt_code_t code;
        code                = '0;
        code[CLASS_BIT]     = cls;
        code[IDX_LSB +: 2]  = idx;
        return code;
    endfunction

endpackage

// File: rtl/button_event_scheduler_if.sv
// Valid/ready event channel from the scheduler to the sale-terminal logic.
interface button_evt_if;
    import button_evt_pkg::*;

    logic      EVT_Valid;
    evt_code_t EVT_Code;
    logic      EVT_Ready;

    modport master (output EVT_Valid, output EVT_Code, input EVT_Ready);
    modport slave  (input EVT_Valid, input EVT_Code, output EVT_Ready);

endinterface

// File: rtl/button_event_scheduler_rr_arbiter.sv
// N-way round-robin arbiter; the pointer marks the highest-priority request.
module rr_arbiter #(
    parameter  int N     = 8,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     i_req,
    input  logic             i_enable,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_grant_valid
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_cand;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    // N is a power of two, so pointer arithmetic wraps for free.
    always_comb begin
        w_found = 1'b0;
        w_idx   = r_ptr;
        w_cand  = r_ptr;
        for (int k = 0; k < N; k++) begin
            w_cand = r_ptr + IDX_W'(k);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    assign o_grant_valid = w_found & i_enable;
    assign o_idx         = w_idx;
    assign o_grant       = o_grant_valid ? (N'(1) << w_idx) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (o_grant_valid) begin
            r_ptr <= w_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/button_event_scheduler.sv
// Latches KEY/CMD pulses, arbitrates them round-robin into a FWFT event FIFO.
// Define CMD_PRIORITY_EN to make any pending CMD beat every KEY.
module button_event_scheduler
    import button_evt_pkg::*;
#(
    parameter  int FIFO_DEPTH = 4,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET,
    input  logic [3:0]           CMD_En,
    input  logic [3:0]           KEY_En,
    input  logic                 Ovf_Clear,
    button_evt_if.master         evt,
    output logic [NUM_REQ-1:0]   Pending,
    output logic [CNT_W-1:0]     FIFO_Count,
    output logic                 Overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [NUM_REQ-1:0] w_pulse;
    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] r_pending;
    logic               w_grant_valid;
    evt_code_t          w_grant_code;
    logic               w_space;
    logic               w_wr;
    logic               w_rd;
    logic               w_valid;
    logic               w_merge;
    logic               r_overflow;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    evt_code_t          r_mem [FIFO_DEPTH];

    assign w_pulse = {CMD_En, KEY_En};
    assign w_space = (r_count < CNT_W'(FIFO_DEPTH));

`ifdef CMD_PRIORITY_EN
    logic [3:0] w_key_grant;
    logic [3:0] w_cmd_grant;
    logic [1:0] w_key_idx;
    logic [1:0] w_cmd_idx;
    logic       w_key_valid;
    logic       w_cmd_valid;
    logic       w_cmd_any;

    // KEY arbiter is only enabled when no CMD is waiting.
    assign w_cmd_any = |r_pending[CMD_BASE +: 4];

    rr_arbiter #(.N(4)) u_cmd_arb (
        .clk           (CLOCK_50),
        .rst           (RESET),
        .i_req         (r_pending[CMD_BASE +: 4]),
        .i_enable      (w_space),
        .o_grant       (w_cmd_grant),
        .o_idx         (w_cmd_idx),
        .o_grant_valid (w_cmd_valid)
    );

    rr_arbiter #(.N(4)) u_key_arb (
        .clk           (CLOCK_50),
        .rst           (RESET),
        .i_req         (r_pending[KEY_BASE +: 4]),
        .i_enable      (w_space & ~w_cmd_any),
        .o_grant       (w_key_grant),
        .o_idx         (w_key_idx),
        .o_grant_valid (w_key_valid)
    );

    assign w_grant       = {w_cmd_grant, w_key_grant};
    assign w_grant_valid = w_cmd_valid | w_key_valid;
    assign w_grant_code  = w_cmd_valid ? make_code(CLS_CMD, w_cmd_idx)
                                       : make_code(CLS_KEY, w_key_idx);
`else
    logic [2:0] w_idx;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk           (CLOCK_50),
        .rst           (RESET),
        .i_req         (r_pending),
        .i_enable      (w_space),
        .o_grant       (w_grant),
        .o_idx         (w_idx),
        .o_grant_valid (w_grant_valid)
    );

    assign w_grant_code = make_code(evt_class_e'(w_idx[2]), w_idx[1:0]);
`endif

    // A press is lost only when its bit is already pending and not being granted.
    assign w_merge = |(w_pulse & r_pending & ~w_grant);

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_grant) | w_pulse;
            if (w_merge) begin
                r_overflow <= 1'b1;
            end else if (Ovf_Clear) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign w_valid = (r_count != '0);
    assign w_wr    = w_grant_valid;
    assign w_rd    = w_valid & evt.EVT_Ready;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge CLOCK_50) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_grant_code;
        end
    end

    assign evt.EVT_Valid = w_valid;
    assign evt.EVT_Code  = w_valid ? r_mem[r_rd_ptr] : '0;
    assign Pending       = r_pending;
    assign FIFO_Count    = r_count;
    assign Overflow      = r_overflow;

endmodule
